// File: rtl/powerup_manager_pkg.sv
// Shared definitions for the Pong power-up sequencer.
// Contents:
//   - Sprite geometry: ball and power-up box sizes in pixels.
//   - FSM state encoding (puState_t).
//   - Registered output bundle (puOut_t).
//   - Helper functions for the overlap test and for clearing the effect.
package powerup_manager_pkg;

  localparam int BALL_W     = 16;
  localparam int BALL_H     = 16;
  localparam int POWER_UP_W = 32;
  localparam int POWER_UP_H = 32;

  typedef enum logic [1:0] {
    PU_WAIT   = 2'd0,
    PU_SHOWN  = 2'd1,
    PU_EFFECT = 2'd2,
    PU_WARN   = 2'd3
  } puState_t;

  // Every output of the block lives in this one register.
  typedef struct packed {
    logic       powerEn;
    logic [9:0] posX;
    logic [8:0] posY;
    logic       isPenalty;
    logic       powerA;
    logic       powerB;
    logic       affectedA;
    logic       affectedB;
    logic       flickA;
    logic       flickB;
    logic       flick;
  } puOut_t;

  // Overlap of the half-open spans [aPos, aPos+aLen) and [bPos, bPos+bLen).
  // The arguments are 11 bits wide, so a sprite at the right or bottom edge
  // cannot wrap around to zero.
  function automatic logic spansOverlap(input logic [10:0] aPos, input logic [10:0] aLen,
                                        input logic [10:0] bPos, input logic [10:0] bLen);
    return (aPos < bPos + bLen) && (bPos < aPos + aLen);
  endfunction

  // Drops the box and every effect flag.
  // The box position and type are left as they were.
  function automatic puOut_t clearEffects(input puOut_t o);
    puOut_t r;
    r           = o;
    r.powerEn   = 1'b0;
    r.powerA    = 1'b0;
    r.powerB    = 1'b0;
    r.affectedA = 1'b0;
    r.affectedB = 1'b0;
    r.flickA    = 1'b0;
    r.flickB    = 1'b0;
    r.flick     = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/powerup_manager_if.sv
// Bundle between the power-up sequencer and the game/display side.
// Game inputs:
//   frame_tick, game_run, x_ball, y_ball, last_hit.
// Display outputs:
//   power_en, power_pos_x/y, affectpowerup,
//   powerA/B, affectedA/B, flickpadA/B, flick.
// Modports:
//   master - used by powerup_manager.
//   slave  - used by the game/display side.
interface powerup_manager_if;
  logic       frame_tick;
  logic       game_run;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic       last_hit;

  logic       power_en;
  logic [9:0] power_pos_x;
  logic [8:0] power_pos_y;
  logic       affectpowerup;
  logic       powerA;
  logic       powerB;
  logic       affectedA;
  logic       affectedB;
  logic       flickpadA;
  logic       flickpadB;
  logic       flick;

  modport master (
    input  frame_tick, game_run, x_ball, y_ball, last_hit,
    output power_en, power_pos_x, power_pos_y, affectpowerup,
           powerA, powerB, affectedA, affectedB, flickpadA, flickpadB, flick
  );

  modport slave (
    output frame_tick, game_run, x_ball, y_ball, last_hit,
    input  power_en, power_pos_x, power_pos_y, affectpowerup,
           powerA, powerB, affectedA, affectedB, flickpadA, flickpadB, flick
  );
endinterface

// File: rtl/powerup_manager_lfsr.sv
// 16-bit Fibonacci LFSR with taps 16, 14, 13 and 11.
// Ports:
//   clk  - clock.
//   rst  - synchronous active-high reset; loads SEED.
//   en   - steps the register when high.
//   lfsr - current value of the register.
module powerup_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] lfsr
);

  // NOTE: clocked state is written with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

endmodule

// File: rtl/powerup_manager.sv
// Power-up sequencer for the Pong display path.
// Once per frame it does three things:
//   - spawns a box at a pseudo-random position;
//   - detects when the ball captures the box;
//   - times the bonus or penalty applied to one paddle, including the
//     warning flicker before the effect expires.
// Ports:
//   clk - pixel clock.
//   rst - synchronous active-high reset.
//   bus - powerup_manager_if master modport. It carries the frame tick, the
//         rally flag, the ball position and last_hit in, and the registered
//         display outputs out.
module powerup_manager
  import powerup_manager_pkg::*;
#(
  parameter int          SPAWN_DELAY   = 300,
  parameter int          SHOW_FRAMES   = 480,
  parameter int          EFFECT_FRAMES = 600,
  parameter int          WARN_FRAMES   = 120,
  parameter int          FLICK_DIV     = 8,
  parameter int          X_MIN         = 192,
  parameter int          Y_MIN         = 96,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  powerup_manager_if.master bus
);

  // Each phase ends on the tick where its frame counter holds these values.
  localparam logic [9:0] SPAWN_LAST  = 10'(SPAWN_DELAY - 1);
  localparam logic [9:0] SHOW_LAST   = 10'(SHOW_FRAMES - 1);
  localparam logic [9:0] EFFECT_LAST = 10'(EFFECT_FRAMES - WARN_FRAMES - 1);
  localparam logic [9:0] WARN_LAST   = 10'(WARN_FRAMES - 1);
  localparam logic [9:0] FLICK_LAST  = 10'(FLICK_DIV - 1);

  puState_t    state, stateNext;
  logic [9:0]  frameCnt, frameCntNext;
  logic [9:0]  flickCnt, flickCntNext;
  puOut_t      outQ, outNext;
  logic [15:0] lfsr;
  logic        captured;

  // The LFSR runs on every cycle, including outside a rally, so the spawn
  // position depends on when the rally starts.
  powerup_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  assign captured =
      spansOverlap({1'b0, bus.x_ball}, 11'(BALL_W), {1'b0, outQ.posX}, 11'(POWER_UP_W)) &&
      spansOverlap({1'b0, bus.y_ball}, 11'(BALL_H), {2'b0, outQ.posY}, 11'(POWER_UP_H));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PU_WAIT;
      frameCnt  <= '0;
      flickCnt  <= '0;
      outQ      <= '0;
      outQ.posX <= 10'(X_MIN);
      outQ.posY <= 9'(Y_MIN);
    end else begin
      state    <= stateNext;
      frameCnt <= frameCntNext;
      flickCnt <= flickCntNext;
      outQ     <= outNext;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    stateNext    = state;
    frameCntNext = frameCnt;
    flickCntNext = flickCnt;
    outNext      = outQ;

    if (!bus.game_run) begin
      // Leaving the rally overrides every other event, on any cycle.
      stateNext    = PU_WAIT;
      frameCntNext = '0;
      flickCntNext = '0;
      outNext      = clearEffects(outQ);
    end else if (bus.frame_tick) begin
      case (state)
        PU_WAIT: begin
          if (frameCnt == SPAWN_LAST) begin
            stateNext         = PU_SHOWN;
            frameCntNext      = '0;
            outNext.powerEn   = 1'b1;
            outNext.posX      = 10'(X_MIN) + {2'b00, lfsr[7:0]};
            outNext.posY      = 9'(Y_MIN) + {1'b0, lfsr[15:8]};
            outNext.isPenalty = lfsr[3] ^ lfsr[12];
          end else begin
            frameCntNext = frameCnt + 10'd1;
          end
        end

        PU_SHOWN: begin
          // A capture on the timeout tick still counts as a capture.
          if (captured) begin
            stateNext       = PU_EFFECT;
            frameCntNext    = '0;
            outNext.powerEn = 1'b0;
            if (!outQ.isPenalty) begin
              // A bonus goes to the paddle that last hit the ball.
              outNext.powerA = ~bus.last_hit;
              outNext.powerB = bus.last_hit;
            end else begin
              // A penalty goes to the opponent of that paddle.
              outNext.affectedA = bus.last_hit;
              outNext.affectedB = ~bus.last_hit;
            end
          end else if (frameCnt == SHOW_LAST) begin
            stateNext       = PU_WAIT;
            frameCntNext    = '0;
            outNext.powerEn = 1'b0;
          end else begin
            frameCntNext = frameCnt + 10'd1;
          end
        end

        PU_EFFECT: begin
          if (frameCnt == EFFECT_LAST) begin
            stateNext      = PU_WARN;
            frameCntNext   = '0;
            flickCntNext   = '0;
            outNext.flick  = 1'b1;
            outNext.flickA = outQ.powerA | outQ.affectedA;
            outNext.flickB = outQ.powerB | outQ.affectedB;
          end else begin
            frameCntNext = frameCnt + 10'd1;
          end
        end

        PU_WARN: begin
          if (frameCnt == WARN_LAST) begin
            stateNext    = PU_WAIT;
            frameCntNext = '0;
            flickCntNext = '0;
            outNext      = clearEffects(outQ);
          end else begin
            frameCntNext = frameCnt + 10'd1;
            if (flickCnt == FLICK_LAST) begin
              flickCntNext  = '0;
              outNext.flick = ~outQ.flick;
            end else begin
              flickCntNext = flickCnt + 10'd1;
            end
          end
        end

        default: stateNext = PU_WAIT;
      endcase
    end
  end

  assign bus.power_en      = outQ.powerEn;
  assign bus.power_pos_x   = outQ.posX;
  assign bus.power_pos_y   = outQ.posY;
  assign bus.affectpowerup = outQ.isPenalty;
  assign bus.powerA        = outQ.powerA;
  assign bus.powerB        = outQ.powerB;
  assign bus.affectedA     = outQ.affectedA;
  assign bus.affectedB     = outQ.affectedB;
  assign bus.flickpadA     = outQ.flickA;
  assign bus.flickpadB     = outQ.flickB;
  assign bus.flick         = outQ.flick;

endmodule

// File: tb/tb_powerup_manager.sv
// Self-checking bench for powerup_manager.
// The main instance uses short phase lengths and is driven with random ticks,
// ball positions and rally drops. A frame-level model predicts every output
// cycle; predictions go into a queue and a monitor on the falling edge
// compares them with the DUT. A second instance with the default parameters
// checks the reset values and the 300-frame spawn delay.
`timescale 1ns/1ps
module tb_powerup_manager;
  import powerup_manager_pkg::*;

  localparam int SPAWN = 4;
  localparam int SHOW  = 3;
  localparam int EFF   = 10;
  localparam int WARN  = 4;
  localparam int FDIV  = 2;
  localparam int XMIN  = 192;
  localparam int YMIN  = 96;
  localparam int SEED  = 'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic rstDef;
  always #5 clk = ~clk;

  powerup_manager_if bus ();
  powerup_manager_if busDef ();

  powerup_manager #(
    .SPAWN_DELAY   (SPAWN),
    .SHOW_FRAMES   (SHOW),
    .EFFECT_FRAMES (EFF),
    .WARN_FRAMES   (WARN),
    .FLICK_DIV     (FDIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  powerup_manager dutDef (
    .clk (clk),
    .rst (rstDef),
    .bus (busDef)
  );

  typedef struct packed {
    logic       pe;
    logic [9:0] px;
    logic [8:0] py;
    logic       ap;
    logic       pA, pB, aA, aB, fA, fB, fl;
  } obs_t;

  typedef enum {IDLE, BOX, BOOST, FLICKER} phase_e;

  int     total = 0;
  int     bad   = 0;
  obs_t   expQ[$];
  obs_t   m;
  phase_e ph;
  int     ticks;
  int     lfsrM;
  obs_t   want;
  obs_t   got;
  logic   prevPe = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, actual, required);
    end
  endtask

  function automatic int lfsrStep(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 'hFFFF;
  endfunction

  function automatic bit ballOnBox(input int bx, input int by, input int px, input int py);
    return (bx < px + POWER_UP_W) && (px < bx + BALL_W) &&
           (by < py + POWER_UP_H) && (py < by + BALL_H);
  endfunction

  // Reference model: tracks which phase the feature is in and how many
  // frames of that phase have passed, and predicts the outputs after each edge.
  always @(posedge clk) begin
    int cur;
    if (rst) begin
      m     = '0;
      m.px  = 10'(XMIN);
      m.py  = 9'(YMIN);
      ph    = IDLE;
      ticks = 0;
      lfsrM = SEED;
    end else begin
      cur   = lfsrM;
      lfsrM = lfsrStep(lfsrM);
      if (!bus.game_run) begin
        ph = IDLE; ticks = 0;
        m.pe = 0; m.pA = 0; m.pB = 0; m.aA = 0; m.aB = 0; m.fA = 0; m.fB = 0; m.fl = 0;
      end else if (bus.frame_tick) begin
        ticks++;
        case (ph)
          IDLE: if (ticks == SPAWN) begin
            ph = BOX; ticks = 0; m.pe = 1;
            m.px = 10'(XMIN + (cur & 255));
            m.py = 9'(YMIN + ((cur >> 8) & 255));
            m.ap = 1'(((cur >> 3) ^ (cur >> 12)) & 1);
          end
          BOX: if (ballOnBox(int'(bus.x_ball), int'(bus.y_ball), int'(m.px), int'(m.py))) begin
            ph = BOOST; ticks = 0; m.pe = 0;
            if (!m.ap) begin
              if (bus.last_hit) m.pB = 1; else m.pA = 1;
            end else begin
              if (bus.last_hit) m.aA = 1; else m.aB = 1;
            end
          end else if (ticks == SHOW) begin
            ph = IDLE; ticks = 0; m.pe = 0;
          end
          BOOST: if (ticks == EFF - WARN) begin
            ph = FLICKER; ticks = 0;
            m.fA = m.pA | m.aA; m.fB = m.pB | m.aB; m.fl = 1;
          end
          FLICKER: if (ticks == WARN) begin
            ph = IDLE; ticks = 0;
            m.pA = 0; m.pB = 0; m.aA = 0; m.aB = 0; m.fA = 0; m.fB = 0; m.fl = 0;
          end else begin
            m.fl = ((ticks / FDIV) % 2) == 0;
          end
          default: ph = IDLE;
        endcase
      end
    end
    expQ.push_back(m);
  end

  // Monitor: compares one prediction per cycle with the DUT outputs.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      want = expQ.pop_front();
      got  = {bus.power_en, bus.power_pos_x, bus.power_pos_y, bus.affectpowerup,
              bus.powerA, bus.powerB, bus.affectedA, bus.affectedB,
              bus.flickpadA, bus.flickpadB, bus.flick};
      check("outputs", 32'(got), 32'(want));
      check("one_effect_flag",
            32'($countones({bus.powerA, bus.powerB, bus.affectedA, bus.affectedB}) <= 1), 32'd1);
      if (bus.power_en && !prevPe && !rst) begin
        check("spawn_range",
              32'((bus.power_pos_x >= 10'd192) && (bus.power_pos_x <= 10'd447) &&
                  (bus.power_pos_y >= 9'd96) && (bus.power_pos_y <= 9'd351)), 32'd1);
      end
      prevPe = bus.power_en;
    end
  end

  initial begin
    int earlySpawns;
    int choice;
    int xv;
    int yv;

    rst = 1'b1;
    rstDef = 1'b1;
    bus.frame_tick = 1'b0; bus.game_run = 1'b1; bus.x_ball = '0; bus.y_ball = '0; bus.last_hit = 1'b0;
    busDef.frame_tick = 1'b0; busDef.game_run = 1'b1; busDef.x_ball = '0; busDef.y_ball = '0;
    busDef.last_hit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values of the default-parameter instance.
    check("rst_pos_x", 32'(busDef.power_pos_x), 32'd192);
    check("rst_pos_y", 32'(busDef.power_pos_y), 32'd96);
    check("rst_flags", 32'({busDef.power_en, busDef.affectpowerup, busDef.powerA, busDef.powerB,
                            busDef.affectedA, busDef.affectedB, busDef.flickpadA, busDef.flickpadB,
                            busDef.flick}), 32'd0);

    // With the default SPAWN_DELAY the box appears only after the 300th tick.
    rstDef = 1'b0;
    earlySpawns = 0;
    for (int t = 1; t <= 300; t++) begin
      busDef.frame_tick = 1'b1;
      @(negedge clk);
      busDef.frame_tick = 1'b0;
      if (t < 300 && busDef.power_en) earlySpawns++;
      if (t == 300) check("spawn_at_300", 32'(busDef.power_en), 32'd1);
      @(negedge clk);
    end
    check("no_early_spawn", 32'(earlySpawns), 32'd0);

    // Random run of the short-parameter instance against the model.
    rst = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      rst = (c >= 4000 && c < 4003);
      bus.frame_tick = ($urandom_range(0, 1) == 1);
      bus.game_run   = ($urandom_range(0, 99) != 0);
      bus.last_hit   = ($urandom_range(0, 1) == 1);
      choice = $urandom_range(0, 9);
      if (ph == BOX && choice <= 3) begin
        xv = int'(m.px) - BALL_W + 1 + $urandom_range(0, BALL_W + POWER_UP_W - 2);
        yv = int'(m.py) - BALL_H + 1 + $urandom_range(0, BALL_H + POWER_UP_H - 2);
      end else if (ph == BOX && choice == 4) begin
        xv = int'(m.px) + POWER_UP_W;
        yv = int'(m.py);
      end else if (ph == BOX && choice == 5) begin
        xv = int'(m.px);
        yv = int'(m.py) - BALL_H;
      end else begin
        xv = $urandom_range(0, 1023);
        yv = $urandom_range(0, 1023);
      end
      bus.x_ball = 10'(xv);
      bus.y_ball = 10'(yv);
      @(negedge clk);
    end

    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/powerup_manager.md
Name: powerup_manager

Overview:
- Sequences the power-up feature of the Pong display path.
- Spawns a power-up box at a pseudo-random field position and detects ball capture, once per frame.
- Applies a timed bonus or penalty to one paddle and drives the warning flicker before expiry.
- Outputs feed the display controller's power_en / power_pos / powerA/B / affectedA/B / affectpowerup / flickpadA/B / flick inputs, plus the paddle-height logic.

Parameters:
- SPAWN_DELAY, 300: frames in WAIT before a spawn (1..1023).
- SHOW_FRAMES, 480: frames a spawned box stays up uncaptured (1..1023).
- EFFECT_FRAMES, 600: total effect duration in frames (must exceed WARN_FRAMES; max 1023).
- WARN_FRAMES, 120: final frames of the effect with flicker (>=1).
- FLICK_DIV, 8: frames per flick half-period (>=1).
- X_MIN, 192: spawn x origin; x = X_MIN + lfsr[7:0].
- Y_MIN, 96: spawn y origin; y = Y_MIN + lfsr[15:8].
- LFSR_SEED, 16'hACE1: LFSR reset value (non-zero).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse per frame (end of visible area)
- game_run  in  1  high while a rally is in play
- x_ball  in  10  ball top-left x
- y_ball  in  10  ball top-left y
- last_hit  in  1  paddle that last touched the ball (0=A, 1=B)
- power_en  out  1  power-up box visible
- power_pos_x  out  10  box x
- power_pos_y  out  9  box y
- affectpowerup  out  1  box type (0=bonus, 1=penalty)
- powerA, powerB  out  1 each  bonus active on that paddle
- affectedA, affectedB  out  1 each  penalty active on that paddle
- flickpadA, flickpadB  out  1 each  paddle in warning window
- flick  out  1  flicker phase

Behaviour:
- All outputs are registered. On rst=1:
  - every output is 0, except power_pos_x=X_MIN and power_pos_y=Y_MIN;
  - state=WAIT, frame counter=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every clk cycle, including when game_run=0, so spawns are timing-random.
- State and counter change only on cycles with frame_tick=1. Outputs reflect the new state one cycle after that tick.
- game_run=0 on any cycle forces WAIT on the next edge:
  - counter=0;
  - all effect outputs, power_en and flick cleared;
  - this has priority over every other event.
- WAIT:
  - counter increments per tick;
  - on the tick where counter==SPAWN_DELAY-1, go to SHOWN and latch:
    - power_pos_x = X_MIN + lfsr[7:0];
    - power_pos_y = Y_MIN + lfsr[15:8];
    - affectpowerup = lfsr[3]^lfsr[12];
  - counter is cleared on this transition.
- SHOWN:
  - power_en=1.
  - Capture = ball box [x_ball, x_ball+BALL_W) x [y_ball, y_ball+BALL_H) overlaps the power-up box [pos, pos+POWER_UP_W/H) on a tick. Compare at 11 bits so there is no wrap.
  - On capture, go to EFFECT with counter=0 and power_en=0:
    - bonus: last_hit=0 sets powerA, last_hit=1 sets powerB;
    - penalty: last_hit=0 sets affectedB, last_hit=1 sets affectedA.
  - On the tick where counter==SHOW_FRAMES-1 with no capture: go to WAIT, power_en=0.
  - Capture and timeout on the same tick: capture wins.
- EFFECT:
  - counter increments per tick;
  - on the tick where counter==EFFECT_FRAMES-WARN_FRAMES-1, go to WARN with counter=0.
- WARN:
  - flickpadX=1 for the paddle whose powerX or affectedX is set.
  - flick toggles every FLICK_DIV ticks; it starts at 1 on WARN entry. Use a separate divider counter.
  - On the tick where counter==WARN_FRAMES-1: go to WAIT with counter=0 and clear powerA/B, affectedA/B, flickpadA/B and flick.
- Mutual exclusion: at most one of powerA, powerB, affectedA, affectedB is 1 at any time.
- affectpowerup holds its last value outside SHOWN.
- Counters are 10 bits wide; parameters above 1023 are illegal.

Decomposition:
- game_config.vh supplies BALL_W, BALL_H, POWER_UP_W and POWER_UP_H, and gains the state encodings PU_WAIT=0, PU_SHOWN=1, PU_EFFECT=2, PU_WARN=3.
- One sub-module: powerup_lfsr (16-bit LFSR with seed parameter and enable).
- FSM, counters and overlap compare stay in powerup_manager.

Test Plan:
- rst=1 for 3 cycles with game_run=1 -> all flags 0, power_pos=(192,96); after release no power_en before the 300th tick.
- SPAWN_DELAY=4, game_run=1, 4 ticks -> power_en=1 exactly one cycle after tick 4; power_pos_x in [192,447] and power_pos_y in [96,351].
- Bonus capture (seed chosen so affectpowerup=0): place ball on box, last_hit=0, tick -> next cycle powerA=1, power_en=0. With EFFECT_FRAMES=10, WARN_FRAMES=4, FLICK_DIV=2: flickpadA=1 after tick 6; flick pattern 1,1,0,0; all cleared after tick 10.
- Penalty capture with last_hit=1 -> affectedA=1, powerB=0; flickpadA asserts in WARN.
- SHOW_FRAMES=3, no ball overlap -> power_en falls after tick 3 and state returns to WAIT. Repeat with overlap on tick 3 -> effect starts (capture wins).
- game_run=0 for one cycle mid-WARN -> next cycle all flags, flick and power_en are 0; the next spawn needs a full SPAWN_DELAY.
